// File: rtl/systolic_pkg.sv
// systolic_pkg: shared definitions for the systolic feed controller.
//   SA_DIM      array edge length (4x4 array)
//   FEED_STEPS  number of skewed operand steps per tile pass (2*SA_DIM-1)
//   STEP_W      width of the feed step counter
//   ELEMS       elements per tile buffer, ADDR_W its index width
//   state_t     controller FSM states
//   elem_idx()  row-major element index helper
package systolic_pkg;

  localparam int SA_DIM     = 4;
  localparam int FEED_STEPS = 2 * SA_DIM - 1;
  localparam int STEP_W     = $clog2(FEED_STEPS);
  localparam int ELEMS      = SA_DIM * SA_DIM;
  localparam int ADDR_W     = $clog2(ELEMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_WAIT,
    S_FIN
  } state_t;

  // Row-major index of element [row][col] in a tile buffer.
  function automatic logic [ADDR_W-1:0] elem_idx(input int row, input int col);
    return ADDR_W'(row * SA_DIM + col);
  endfunction

endpackage

// File: rtl/systolic_tile_buf.sv
// systolic_tile_buf: one SA_DIM x SA_DIM tile of DW-bit operands.
//   clk      system clock
//   rst      synchronous active-high reset, clears every element
//   wr_en    write strobe
//   wr_addr  element index, row*SA_DIM+col
//   wr_data  element value
//   elems    parallel read of all elements, row-major
import systolic_pkg::*;

module systolic_tile_buf #(
  parameter int DW = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DW-1:0]              wr_data,
  output logic [ELEMS-1:0][DW-1:0]   elems
);

  // NOTE: this is a small flop array read in parallel, not a RAM macro, so it
  // can and must be reset; a pass started right after reset sees all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      elems <= '0;
    end else if (wr_en) begin
      elems[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// systolic_feed_ctrl: sequencing controller for the 4x4 systolic_array.
// Holds one A and one B tile, and on start clears the array, drives the
// diagonally skewed west/north operand streams for FEED_STEPS cycles, waits
// for the array's done and pulses done for one cycle.
//
// Optional feature: define SYSTOLIC_FEED_WATCHDOG_EN to bound WAIT to TIMEOUT
// cycles; on expiry err sets (sticky until rst) and the pass still finishes.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   load_en/sel/addr/data    tile buffer write (sel 0 = A, 1 = B), IDLE only
//   start                    begin a tile pass, sampled in IDLE only
//   sa_done                  done from systolic_array, sampled in WAIT only
//   sa_rst                   reset to systolic_array (rst or CLEAR state)
//   west0..3, north0..3      registered operand streams to the array
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse at end of pass
//   err                      sticky watchdog flag (0 without the watchdog)
import systolic_pkg::*;

module systolic_feed_ctrl #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              load_sel,
  input  logic [3:0]        load_addr,
  input  logic [DW-1:0]     load_data,
  input  logic              start,
  input  logic              sa_done,
  output logic              sa_rst,
  output logic [DW-1:0]     west0,
  output logic [DW-1:0]     west1,
  output logic [DW-1:0]     west2,
  output logic [DW-1:0]     west3,
  output logic [DW-1:0]     north0,
  output logic [DW-1:0]     north1,
  output logic [DW-1:0]     north2,
  output logic [DW-1:0]     north3,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(FEED_STEPS - 1);

  state_t                        state;
  logic [STEP_W-1:0]             step;
  logic [ELEMS-1:0][DW-1:0]      a_elems;
  logic [ELEMS-1:0][DW-1:0]      b_elems;
  logic [SA_DIM-1:0][DW-1:0]     west_q;
  logic [SA_DIM-1:0][DW-1:0]     north_q;
  logic [SA_DIM-1:0][DW-1:0]     west_nxt;
  logic [SA_DIM-1:0][DW-1:0]     north_nxt;
  logic                          op_valid;
  logic [STEP_W-1:0]             op_step;
  logic                          wr_ok;

  // Buffers only accept writes in IDLE so they stay stable during a pass.
  assign wr_ok = load_en && (state == S_IDLE);

  systolic_tile_buf #(.DW(DW)) u_buf_a (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok && !load_sel),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .elems   (a_elems)
  );

  systolic_tile_buf #(.DW(DW)) u_buf_b (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok && load_sel),
    .wr_addr (load_addr),
    .wr_data (load_data),
    .elems   (b_elems)
  );

  // Operands for the step that becomes active on the next edge: step 0 when
  // leaving CLEAR, step+1 while feeding, nothing after the last step.
  // Lane i sees inner index k = 3-(t-i), so k descends from 3 to 0.
  // NOTE: every variable gets a default before any branch so no latch forms.
  always_comb begin
    op_valid  = 1'b0;
    op_step   = '0;
    west_nxt  = '0;
    north_nxt = '0;
    case (state)
      S_CLEAR: op_valid = 1'b1;
      S_FEED: begin
        if (step != STEP_LAST) begin
          op_valid = 1'b1;
          op_step  = step + 1'b1;
        end
      end
      default: ;
    endcase
    if (op_valid) begin
      for (int i = 0; i < SA_DIM; i++) begin
        if (int'(op_step) >= i && int'(op_step) - i < SA_DIM) begin
          west_nxt[i]  = a_elems[elem_idx(i, SA_DIM - 1 - (int'(op_step) - i))];
          north_nxt[i] = b_elems[elem_idx(SA_DIM - 1 - (int'(op_step) - i), i)];
        end
      end
    end
  end

`ifdef SYSTOLIC_FEED_WATCHDOG_EN
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [WD_W-1:0] wait_cnt;
  logic            err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
  // TIMEOUT has no effect without the watchdog; a value below 1 is invalid.
  if (TIMEOUT < 1) begin : g_timeout_invalid
  end
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // here samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      step    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      west_q  <= '0;
      north_q <= '0;
`ifdef SYSTOLIC_FEED_WATCHDOG_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      west_q  <= west_nxt;
      north_q <= north_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CLEAR;
            busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          state <= S_FEED;
          step  <= '0;
        end
        S_FEED: begin
          if (step == STEP_LAST) begin
            state <= S_WAIT;
            step  <= '0;
`ifdef SYSTOLIC_FEED_WATCHDOG_EN
            wait_cnt <= '0;
`endif
          end else begin
            step <= step + 1'b1;
          end
        end
        S_WAIT: begin
          if (sa_done) begin
            state <= S_FIN;
            done  <= 1'b1;
          end
`ifdef SYSTOLIC_FEED_WATCHDOG_EN
          else if (wait_cnt == WD_W'(TIMEOUT - 1)) begin
            state <= S_FIN;
            done  <= 1'b1;
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        S_FIN: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Array reset follows controller reset directly so it is held while rst is.
  assign sa_rst = rst || (state == S_CLEAR);

  assign west0  = west_q[0];
  assign west1  = west_q[1];
  assign west2  = west_q[2];
  assign west3  = west_q[3];
  assign north0 = north_q[0];
  assign north1 = north_q[1];
  assign north2 = north_q[2];
  assign north3 = north_q[3];

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb_systolic_feed_ctrl: directed self-checking bench for systolic_feed_ctrl.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_systolic_feed_ctrl;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_en;
  logic          load_sel;
  logic [3:0]    load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic          sa_done;
  logic          sa_rst;
  logic [DW-1:0] west0, west1, west2, west3;
  logic [DW-1:0] north0, north1, north2, north3;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  systolic_feed_ctrl #(.DW(DW), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_addr (load_addr),
    .load_data (load_data),
    .start     (start),
    .sa_done   (sa_done),
    .sa_rst    (sa_rst),
    .west0     (west0),
    .west1     (west1),
    .west2     (west2),
    .west3     (west3),
    .north0    (north0),
    .north1    (north1),
    .north2    (north2),
    .north3    (north3),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [3:0] addr, input logic [DW-1:0] data);
    load_sel  = sel;
    load_addr = addr;
    load_data = data;
    load_en   = 1'b1;
    tick();
    load_en   = 1'b0;
  endtask

  // Hand-derived streams for A = B = 0..15 row-major, t = 0..6.
  int exp_w0[7] = '{3, 2, 1, 0, 0, 0, 0};
  int exp_w1[7] = '{0, 7, 6, 5, 4, 0, 0};
  int exp_w2[7] = '{0, 0, 11, 10, 9, 8, 0};
  int exp_w3[7] = '{0, 0, 0, 15, 14, 13, 12};
  int exp_n0[7] = '{12, 8, 4, 0, 0, 0, 0};
  int exp_n1[7] = '{0, 13, 9, 5, 1, 0, 0};
  int exp_n2[7] = '{0, 0, 14, 10, 6, 2, 0};
  int exp_n3[7] = '{0, 0, 0, 15, 11, 7, 3};

  initial begin
    int bad_busy;
    int bad_done;
    rst = 1'b1; load_en = 1'b0; load_sel = 1'b0; load_addr = '0;
    load_data = '0; start = 1'b0; sa_done = 1'b0;

    // Reset state
    tick(); tick();
    check("rst_sa_rst", 32'(sa_rst), 1);
    check("rst_busy",   32'(busy),   0);
    check("rst_done",   32'(done),   0);
    check("rst_err",    32'(err),    0);
    check("rst_west0",  west0,  0);
    check("rst_north3", north3, 0);
    rst = 1'b0;
    tick();
    check("idle_sa_rst", 32'(sa_rst), 0);

    // Pass 1: skew pattern, handshake, ignored inputs during FEED
    for (int i = 0; i < 16; i++) begin
      load(1'b0, 4'(i), DW'(i));
      load(1'b1, 4'(i), DW'(i));
    end
    start = 1'b1;               // cycle 0
    tick();                     // cycle 1: CLEAR
    start = 1'b0;
    check("p1_clear_sa_rst", 32'(sa_rst), 1);
    check("p1_clear_busy",   32'(busy),   1);
    for (int t = 0; t < 7; t++) begin
      tick();                   // cycle t+2
      check($sformatf("p1_west0_t%0d", t),  west0,  exp_w0[t]);
      check($sformatf("p1_west1_t%0d", t),  west1,  exp_w1[t]);
      check($sformatf("p1_west2_t%0d", t),  west2,  exp_w2[t]);
      check($sformatf("p1_west3_t%0d", t),  west3,  exp_w3[t]);
      check($sformatf("p1_north0_t%0d", t), north0, exp_n0[t]);
      check($sformatf("p1_north1_t%0d", t), north1, exp_n1[t]);
      check($sformatf("p1_north2_t%0d", t), north2, exp_n2[t]);
      check($sformatf("p1_north3_t%0d", t), north3, exp_n3[t]);
      check($sformatf("p1_feed_sa_rst_t%0d", t), 32'(sa_rst), 0);
      if (t == 2) begin
        start = 1'b1; load_sel = 1'b0; load_addr = 4'd0; load_data = 99; load_en = 1'b1;
      end else begin
        start = 1'b0; load_en = 1'b0;
      end
    end
    for (int w = 0; w < 6; w++) begin
      tick();                   // cycles 9..14: WAIT
      check($sformatf("p1_wait_done_%0d", w),  32'(done), 0);
      check($sformatf("p1_wait_busy_%0d", w),  32'(busy), 1);
      check($sformatf("p1_wait_west0_%0d", w), west0, 0);
      check($sformatf("p1_wait_north3_%0d", w), north3, 0);
      if (w == 5) sa_done = 1'b1;
    end
    tick();                     // cycle 15: FIN
    sa_done = 1'b0;
    check("p1_fin_done", 32'(done), 1);
    check("p1_fin_busy", 32'(busy), 1);
    tick();                     // cycle 16: IDLE
    check("p1_idle_done", 32'(done), 0);
    check("p1_idle_busy", 32'(busy), 0);
    tick();
    check("p1_no_restart", 32'(busy), 0);

    // Pass 2: simultaneous load and start, minimum-length pass
    load_sel = 1'b1; load_addr = 4'd12; load_data = 77; load_en = 1'b1;
    start = 1'b1; sa_done = 1'b1;
    tick();                     // cycle 1
    load_en = 1'b0; start = 1'b0;
    tick();                     // cycle 2: t=0
    check("p2_north0_t0", north0, 77);
    check("p2_west0_t0",  west0,  3);
    tick(); tick(); tick();     // cycle 5: t=3
    check("p2_west0_t3_not99", west0, 0);
    tick(); tick(); tick();     // cycle 8: t=6
    check("p2_t6_done", 32'(done), 0);
    tick();                     // cycle 9: WAIT
    check("p2_wait_done", 32'(done), 0);
    tick();                     // cycle 10: FIN
    sa_done = 1'b0;
    check("p2_fin_done", 32'(done), 1);
    tick();                     // cycle 11: IDLE, back-to-back start
    check("p2_idle_busy", 32'(busy), 0);
    check("p2_idle_done", 32'(done), 0);
    start = 1'b1;

    // Pass 3: accepted back-to-back, then reset mid-FEED at t=3
    tick();                     // CLEAR
    start = 1'b0;
    check("p3_b2b_busy",   32'(busy),   1);
    check("p3_b2b_sa_rst", 32'(sa_rst), 1);
    tick(); tick(); tick(); tick();   // t=3
    check("p3_west1_t3", west1, 5);
    rst = 1'b1;
    #1;
    check("p3_rst_sa_rst", 32'(sa_rst), 1);
    tick();
    rst = 1'b0;
    #1;
    check("p3_after_busy",   32'(busy),   0);
    check("p3_after_done",   32'(done),   0);
    check("p3_after_west1",  west1,  0);
    check("p3_after_north3", north3, 0);
    check("p3_after_sa_rst", 32'(sa_rst), 0);
    bad_done = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad_done++;
    end
    check("p3_no_done_after_rst", 32'(bad_done), 0);

    // Pass 4: buffers cleared by reset; sa_done never arrives
    start = 1'b1;
    tick();                     // CLEAR
    start = 1'b0;
    tick();                     // t=0
    check("p4_west0_cleared",  west0,  0);
    check("p4_north0_cleared", north0, 0);
    for (int c = 0; c < 6; c++) tick();   // cycle 8
`ifdef SYSTOLIC_FEED_WATCHDOG_EN
    bad_done = 0;
    for (int c = 0; c < 8; c++) begin
      tick();                   // cycles 9..16: WAIT
      if (done !== 1'b0) bad_done++;
    end
    check("p4_wd_wait_no_done", 32'(bad_done), 0);
    tick();                     // cycle 17: FIN
    check("p4_wd_done", 32'(done), 1);
    check("p4_wd_err",  32'(err),  1);
    tick();
    check("p4_wd_idle_done", 32'(done), 0);
    check("p4_wd_idle_busy", 32'(busy), 0);
    check("p4_wd_err_sticky", 32'(err), 1);
`else
    bad_busy = 0;
    bad_done = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0 || err !== 1'b0) bad_done++;
    end
    check("p4_hang_busy", 32'(bad_busy), 0);
    check("p4_hang_done_err", 32'(bad_done), 0);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("end_busy", 32'(busy), 0);
    check("end_err",  32'(err),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
